ex_pipe: RTL and testbench

EX_PIPE -- requirements
Module: ex_pipe

---
 rtl/ex_pkg.sv | 24 ++
 rtl/ex_lane.sv | 91 +++++++++
 rtl/ex_pipe.sv | 114 +++++++++++
 tb/tb_ex_pipe.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared constants and per-lane pipeline stage records for the ex_pipe exponent unit.
// Field widths cover the supported envelope IN_W <= 12, IN_FRAC 6..12.
package ex_pkg;

    localparam int LOG2E_Q6 = 92;
    localparam int LN2_Q6   = 44;
    localparam int ONE_Q16  = 65536;

    // |n| stays below ~50 and |r| below 2.0 real for IN_W <= 12, so e < 2^19 in Q.16
    localparam int N_W = 8;
    localparam int R_W = 16;
    localparam int E_W = 24;

    typedef struct packed {
        logic signed [N_W-1:0] n;
        logic signed [R_W-1:0] r;
    } s1_t;

    typedef struct packed {
        logic signed [N_W-1:0] n;
        logic signed [E_W-1:0] e;
    } s2_t;

endpackage

// File: rtl/ex_lane.sv
// One lane of e^x: range reduction, 2nd-order polynomial in Q.16, then scale by 2^n
// and saturate to the unsigned output format. All three stages share one enable.
module ex_lane
    import ex_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 6,
    parameter int OUT_W    = 9,
    parameter int OUT_FRAC = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y,
    output logic             sat
);

    localparam int     HALF  = 1 << (IN_FRAC - 1);
    localparam int     LN2_S = LN2_Q6 << (IN_FRAC - 6);
    localparam longint MAXV  = (longint'(1) <<< OUT_W) - 1;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    logic [OUT_W-1:0] y_d;
    logic             sat_d;

    int     xs, t, n32, r32;
    longint rq, sq, e64;
    longint ev, sh, v;
    int     ns;
    logic   big;

    // S1: n = round(x*log2e) with the bias toward -inf on negatives, r = x - n*ln2
    always_comb begin
        xs   = int'($signed(x));
        t    = (xs * LOG2E_Q6) >>> 6;
        n32  = (t + ((t < 0) ? -HALF : HALF)) >>> IN_FRAC;
        r32  = xs - n32 * LN2_S;
        s1_d = '{n: N_W'(n32), r: R_W'(r32)};
    end

    // S2: e = 1 + r + r^2/2 evaluated in Q.16
    always_comb begin
        rq   = longint'($signed(s1_q.r)) <<< (16 - IN_FRAC);
        sq   = (rq * rq) >>> 16;
        e64  = longint'(ONE_Q16) + rq + (sq >>> 1);
        s2_d = '{n: s1_q.n, e: E_W'(e64)};
    end

    // S3: large positive n is resolved to saturation before shifting, so the
    // shifter never needs more than OUT_W+2 bits of headroom above e
    always_comb begin
        ns    = int'($signed(s2_q.n));
        ev    = longint'($signed(s2_q.e));
        big   = 1'b0;
        sh    = 0;
        y_d   = '0;
        sat_d = 1'b0;
        if (ns > OUT_W + 1)
            big = 1'b1;
        else if (ns >= 0)
            sh = ev <<< ns;
        else
            sh = ev >>> (-ns);
        v = sh >>> (16 - OUT_FRAC);
        if (ev <= 0 || v < 0) begin
            y_d = '0;
        end else if (big || v > MAXV) begin
            y_d   = OUT_W'(MAXV);
            sat_d = 1'b1;
        end else begin
            y_d = OUT_W'(v);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            y    <= '0;
            sat  <= 1'b0;
        end else if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            y    <= y_d;
            sat  <= sat_d;
        end
    end

endmodule

// File: rtl/ex_pipe.sv
// LANES-wide e^x pipeline with one valid/ready handshake, row framing via in_last
// and a saturating per-row denominator emitted as a one-cycle pulse.
module ex_pipe
    import ex_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 6,
    parameter int OUT_W    = 9,
    parameter int OUT_FRAC = 6,
    parameter int SUM_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_last,
    output logic [LANES-1:0]       out_sat,
    output logic                   sum_valid,
    output logic [SUM_W-1:0]       sum_data
);

    localparam int STAGES = 3;
    localparam int BS_W   = OUT_W + $clog2(LANES + 1);
    localparam int T_W    = ((SUM_W > BS_W) ? SUM_W : BS_W) + 1;
    localparam logic [T_W-1:0] SUM_MAX = T_W'({SUM_W{1'b1}});

    if (IN_FRAC < 6 || IN_FRAC > 12) begin : g_bad_in_frac
        $error("ex_pipe: IN_FRAC must be in 6..12");
    end
    if (OUT_FRAC < 0 || OUT_FRAC > 16) begin : g_bad_out_frac
        $error("ex_pipe: OUT_FRAC must be in 0..16");
    end
    if (IN_W > 12) begin : g_bad_in_w
        $error("ex_pipe: lane stage fields are sized for IN_W <= 12");
    end

    logic              en;
    logic [STAGES:0]   vld_pipe, last_pipe;
    logic [STAGES:1]   vld_q, last_q;

    assign vld_pipe  = {vld_q, in_valid};
    assign last_pipe = {last_q, in_last};

    assign out_valid = vld_pipe[STAGES];
    assign out_last  = last_pipe[STAGES];
    assign en        = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = en;

    // A bubble entering S1 carries its last bit too; it is masked by the valid bit downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
        end else if (en) begin
            vld_q  <= vld_pipe[STAGES-1:0];
            last_q <= last_pipe[STAGES-1:0];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ex_lane #(
            .IN_W    (IN_W),
            .IN_FRAC (IN_FRAC),
            .OUT_W   (OUT_W),
            .OUT_FRAC(OUT_FRAC)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .en (en),
            .x  (in_data[i*IN_W +: IN_W]),
            .y  (out_data[i*OUT_W +: OUT_W]),
            .sat(out_sat[i])
        );
    end

    logic [BS_W-1:0]  beat_sum;
    logic [T_W-1:0]   total;
    logic [SUM_W-1:0] acc, acc_nxt;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++)
            beat_sum = beat_sum + BS_W'(out_data[i*OUT_W +: OUT_W]);
        total   = T_W'(acc) + T_W'(beat_sum);
        acc_nxt = (total > SUM_MAX) ? {SUM_W{1'b1}} : total[SUM_W-1:0];
    end

    // The sum pulse does not wait on out_ready; it fires the cycle after the last beat leaves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sum_valid <= 1'b0;
            sum_data  <= '0;
        end else begin
            sum_valid <= 1'b0;
            if (out_valid && out_ready) begin
                if (out_last) begin
                    acc       <= '0;
                    sum_valid <= 1'b1;
                    sum_data  <= acc_nxt;
                end else begin
                    acc <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_pipe.sv
// Scoreboard bench for ex_pipe: defaults, plus OUT_W=8 and SUM_W=9 copies on shared stimulus.
module tb_ex_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = '0;

    logic        in_ready, out_valid, out_last, sum_valid;
    logic [35:0] out_data;
    logic [3:0]  out_sat;
    logic [15:0] sum_data;

    logic        w8_in_ready, w8_out_valid, w8_out_last, w8_sum_valid;
    logic [31:0] w8_out_data;
    logic [3:0]  w8_out_sat;
    logic [15:0] w8_sum_data;

    logic        s9_in_ready, s9_out_valid, s9_out_last, s9_sum_valid;
    logic [35:0] s9_out_data;
    logic [3:0]  s9_out_sat;
    logic [8:0]  s9_sum_data;

    always #5 clk = ~clk;

    ex_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sat(out_sat), .sum_valid(sum_valid), .sum_data(sum_data)
    );

    ex_pipe #(.OUT_W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w8_in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(w8_out_valid), .out_ready(out_ready), .out_data(w8_out_data),
        .out_last(w8_out_last), .out_sat(w8_out_sat), .sum_valid(w8_sum_valid), .sum_data(w8_sum_data)
    );

    ex_pipe #(.SUM_W(9)) u_s9 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s9_in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(s9_out_valid), .out_ready(out_ready), .out_data(s9_out_data),
        .out_last(s9_out_last), .out_sat(s9_out_sat), .sum_valid(s9_sum_valid), .sum_data(s9_sum_data)
    );

    typedef struct {
        logic [35:0] d9;
        logic [31:0] d8;
        logic [3:0]  s9;
        logic [3:0]  s8;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   sum16_q[$];
    int   sum9_q[$];
    int   macc16 = 0, macc9 = 0;
    int   checks = 0, errors = 0;
    int   n_out = 0, sum_cnt = 0;
    int   last_sum16 = -1, last_sum9 = -1;
    bit   toggle_en = 1'b0;

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Straight integer evaluation of the exponent formula at the default formats
    function automatic void ref_exp(input int x, input int out_w, output int y, output bit s);
        longint t, n, r, rq, sq, e, v, maxv;
        t    = fdiv(longint'(92 * x), 64);
        n    = fdiv(t + ((t < 0) ? -32 : 32), 64);
        r    = x - n * 44;
        rq   = r * 1024;
        sq   = fdiv(rq * rq, 65536);
        e    = 65536 + rq + fdiv(sq, 2);
        if (n >= 0) v = e * (longint'(1) << n);
        else        v = fdiv(e, longint'(1) << (-n));
        v    = fdiv(v, 1024);
        maxv = (longint'(1) << out_w) - 1;
        s    = 1'b0;
        if (v < 0) y = 0;
        else if (v > maxv) begin y = int'(maxv); s = 1'b1; end
        else y = int'(v);
    endfunction

    function automatic void push_exp(input logic [31:0] din, input logic last);
        exp_t e;
        int   y, bs;
        bit   s;
        bs   = 0;
        e.d9 = '0; e.d8 = '0; e.s9 = '0; e.s8 = '0;
        for (int i = 0; i < 4; i++) begin
            int x;
            x = int'($signed(din[i*8 +: 8]));
            ref_exp(x, 9, y, s);
            e.d9[i*9 +: 9] = 9'(y);
            e.s9[i] = s;
            bs += y;
            ref_exp(x, 8, y, s);
            e.d8[i*8 +: 8] = 8'(y);
            e.s8[i] = s;
        end
        e.last = last;
        exp_q.push_back(e);
        macc16 = (macc16 + bs > 65535) ? 65535 : macc16 + bs;
        macc9  = (macc9 + bs > 511) ? 511 : macc9 + bs;
        if (last) begin
            sum16_q.push_back(macc16);
            sum9_q.push_back(macc9);
            macc16 = 0;
            macc9  = 0;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (toggle_en) out_ready = !out_ready;
    end

    // Output monitor: scoreboard pops, stall stability, ready rule, sum pulse timing
    logic [35:0] prev_data;
    logic [3:0]  prev_sat;
    logic        prev_last;
    bit          prev_stall = 1'b0, pulse_exp = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            pulse_exp  = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b want %b", in_ready, (!out_valid || out_ready));
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_sat !== prev_sat || out_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev_data);
                end
            end
            checks++;
            if (sum_valid !== pulse_exp || s9_sum_valid !== pulse_exp) begin
                errors++;
                $display("FAIL sum_valid: got %b/%b want %b", sum_valid, s9_sum_valid, pulse_exp);
            end
            if (sum_valid && pulse_exp) begin
                sum_cnt++;
                last_sum16 = int'(sum_data);
                last_sum9  = int'(s9_sum_data);
                checks++;
                if (sum16_q.size() == 0 || sum9_q.size() == 0) begin
                    errors++;
                    $display("FAIL sum_unexpected: got %0d with empty scoreboard", sum_data);
                end else begin
                    int e16, e9;
                    e16 = sum16_q.pop_front();
                    e9  = sum9_q.pop_front();
                    if (int'(sum_data) != e16 || int'(s9_sum_data) != e9) begin
                        errors++;
                        $display("FAIL sum_data: got %0d/%0d want %0d/%0d", sum_data, s9_sum_data, e16, e9);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got %h with empty scoreboard", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.d9 || out_sat !== e.s9 || out_last !== e.last ||
                        w8_out_data !== e.d8 || w8_out_sat !== e.s8) begin
                        errors++;
                        $display("FAIL beat: got %h s%b l%b w8 %h s%b want %h s%b l%b w8 %h s%b",
                                 out_data, out_sat, out_last, w8_out_data, w8_out_sat,
                                 e.d9, e.s9, e.last, e.d8, e.s8);
                    end
                end
            end
            pulse_exp  = out_valid && out_ready && out_last;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_sat   = out_sat;
            prev_last  = out_last;
        end
    end

    // Tasks start and end at posedge+1
    task automatic send_beat(input logic [31:0] d, input logic last);
        bit acc;
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                push_exp(d, last);
                break;
            end
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck low, got 0 want 1");
                break;
            end
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0 || sum16_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats %0d sums left want 0 0", exp_q.size(), sum16_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got v%b d%h s%b l%b want all 0", out_valid, out_data, out_sat, out_last);
        end
        checks++;
        if (sum_valid !== 1'b0 || sum_data !== '0) begin
            errors++;
            $display("FAIL reset_sum: got v%b d%0d want 0 0", sum_valid, sum_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got rdy%b v%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        out_ready = 1'b1;
        send_beat({8'h80, 8'h7f, 8'h40, 8'h00}, 1'b1);
        idle_in();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c == 3)) begin
                errors++;
                $display("FAIL latency c%0d: got %b want %b", c, out_valid, (c == 3));
            end
        end
        checks++;
        if (out_data !== {9'd8, 9'd473, 9'd174, 9'd64} || out_sat !== 4'b0000) begin
            errors++;
            $display("FAIL vec_w9: got %h s%b want %h s0000", out_data, out_sat, {9'd8, 9'd473, 9'd174, 9'd64});
        end
        checks++;
        if (w8_out_data !== {8'd8, 8'd255, 8'd174, 8'd64} || w8_out_sat !== 4'b0100) begin
            errors++;
            $display("FAIL vec_w8: got %h s%b want %h s0100", w8_out_data, w8_out_sat, {8'd8, 8'd255, 8'd174, 8'd64});
        end
        @(posedge clk); #1;
        wait_drain();
        checks++;
        if (last_sum16 != 719 || last_sum9 != 511) begin
            errors++;
            $display("FAIL vec_sum: got %0d/%0d want 719/511", last_sum16, last_sum9);
        end
    endtask

    task automatic test_random();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            send_beat($urandom, (i == 3 || i == 7));
        idle_in();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int n0, s0;
        n0 = n_out;
        s0 = sum_cnt;
        toggle_en = 1'b1;
        for (int i = 0; i < 10; i++)
            send_beat($urandom, (i == 4 || i == 9));
        idle_in();
        wait_drain();
        toggle_en = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (n_out - n0 != 10 || sum_cnt - s0 != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats %0d sums want 10 2", n_out - n0, sum_cnt - s0);
        end
    endtask

    task automatic test_row_sum();
        int s0;
        out_ready = 1'b1;
        s0 = sum_cnt;
        send_beat(32'h0, 1'b0);
        send_beat(32'h0, 1'b1);
        idle_in();
        wait_drain();
        checks++;
        if (last_sum16 != 512 || sum_cnt - s0 != 1) begin
            errors++;
            $display("FAIL row2_zero: got %0d (%0d pulses) want 512 (1)", last_sum16, sum_cnt - s0);
        end
        send_beat(32'h0, 1'b1);
        idle_in();
        wait_drain();
        checks++;
        if (last_sum16 != 256) begin
            errors++;
            $display("FAIL row1_zero: got %0d want 256", last_sum16);
        end
        send_beat({4{8'h7f}}, 1'b0);
        send_beat({4{8'h7f}}, 1'b1);
        idle_in();
        wait_drain();
        checks++;
        if (last_sum9 != 511 || last_sum16 != 3784) begin
            errors++;
            $display("FAIL row_sat: got %0d/%0d want 3784/511", last_sum16, last_sum9);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_beat({4{8'h40}}, 1'b0);
        idle_in();
        wait_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_beat({4{8'h40}}, 1'b0);
        idle_in();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out: got v%b d%h s%b l%b want all 0", out_valid, out_data, out_sat, out_last);
        end
        checks++;
        if (sum_valid !== 1'b0 || sum_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_sum: got v%b d%0d rdy%b want 0 0 1", sum_valid, sum_data, in_ready);
        end
        exp_q.delete();
        sum16_q.delete();
        sum9_q.delete();
        macc16 = 0;
        macc9  = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send_beat(32'h0, 1'b1);
        idle_in();
        wait_drain();
        checks++;
        if (last_sum16 != 256 || last_sum9 != 256) begin
            errors++;
            $display("FAIL midrst_row: got %0d/%0d want 256/256", last_sum16, last_sum9);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_row_sum();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
